// File: rtl/fibre_a_spike_responder.sv
// Fibre A spike-bitmap responder: single-port mask array with an in-order
// request FIFO, loader writes preempting reads, and a fixed-latency response pipe.
module fibre_a_spike_responder #(
    parameter int TIMESTEPS     = 4,
    parameter int ADDR_WIDTH    = 8,
    parameter int READ_LATENCY  = 2,
    parameter int PENDING_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fibre_a_read_en,
    input  logic [ADDR_WIDTH-1:0] fibre_a_addr,
    output logic [TIMESTEPS-1:0]  fibre_a_data,
    output logic                  fibre_a_valid,
    output logic                  req_ready,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [TIMESTEPS-1:0]  wr_data,
    output logic                  busy,
    output logic                  req_overflow
);

    localparam int MEM_DEPTH = 1 << ADDR_WIDTH;
    localparam int PTR_W     = $clog2(PENDING_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PENDING_DEPTH);

    logic [TIMESTEPS-1:0]  mem_q  [MEM_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_q [PENDING_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q, ready_d;
    logic             ovf_q, ovf_d;

    logic [READ_LATENCY-1:0] vld_q;
    logic [TIMESTEPS-1:0]    data_q [READ_LATENCY];

    logic                  accept;
    logic                  queued;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] issue_addr;

    assign accept = fibre_a_read_en & ready_q;
    assign queued = (count_q != '0);

    // One array action per edge: write, else queued read, else bypass read.
    always_comb begin
        push       = 1'b0;
        pop        = 1'b0;
        issue      = 1'b0;
        issue_addr = fibre_a_addr;
        if (wr_en) begin
            push = accept;
        end else if (queued) begin
            pop        = 1'b1;
            issue      = 1'b1;
            issue_addr = fifo_q[rd_ptr_q];
            push       = accept;
        end else if (accept) begin
            issue = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        ready_d  = (count_d != FULL_CNT);
        ovf_d    = ovf_q | (fibre_a_read_en & ~ready_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage arrays are intentionally left out of reset so a reset keeps the masks.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= fibre_a_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Data only advances with a valid bit, so the last stage holds the previous response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= issue;
            if (issue) begin
                data_q[0] <= mem_q[issue_addr];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign fibre_a_valid = vld_q[READ_LATENCY-1];
    assign fibre_a_data  = data_q[READ_LATENCY-1];
    assign req_ready     = ready_q;
    assign busy          = queued | (|vld_q);
    assign req_overflow  = ovf_q;

endmodule

// File: tb/tb_fibre_a_spike_responder.sv
// Bench for fibre_a_spike_responder: vector table, directed overflow/reset
// sequences, and a randomized run against a transaction-level reference model.
module tb_fibre_a_spike_responder;

    localparam int TS = 4;
    localparam int AW = 8;
    localparam int RL = 2;
    localparam int PD = 4;

    logic          clk;
    logic          rst_n;
    logic          fibre_a_read_en;
    logic [AW-1:0] fibre_a_addr;
    logic [TS-1:0] fibre_a_data;
    logic          fibre_a_valid;
    logic          req_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [TS-1:0] wr_data;
    logic          busy;
    logic          req_overflow;

    fibre_a_spike_responder #(
        .TIMESTEPS(TS), .ADDR_WIDTH(AW), .READ_LATENCY(RL), .PENDING_DEPTH(PD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .fibre_a_read_en(fibre_a_read_en), .fibre_a_addr(fibre_a_addr),
        .fibre_a_data(fibre_a_data), .fibre_a_valid(fibre_a_valid),
        .req_ready(req_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .req_overflow(req_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic w, input int wa, input logic [TS-1:0] wd,
                        input logic r, input int ra);
        wr_en           = w;
        wr_addr         = AW'(wa);
        wr_data         = wd;
        fibre_a_read_en = r;
        fibre_a_addr    = AW'(ra);
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic v, input logic [TS-1:0] d,
                              input logic rdy, input logic b, input logic o);
        check({tag, " valid"}, 32'(fibre_a_valid), 32'(v));
        check({tag, " data"},  32'(fibre_a_data),  32'(d));
        check({tag, " ready"}, 32'(req_ready),     32'(rdy));
        check({tag, " busy"},  32'(busy),          32'(b));
        check({tag, " ovf"},   32'(req_overflow),  32'(o));
    endtask

    typedef struct {
        logic          wr;
        int            wa;
        logic [TS-1:0] wd;
        logic          rd;
        int            ra;
        logic          vld;
        logic [TS-1:0] dat;
        logic          rdy;
        logic          bsy;
        logic          ovf;
    } vec_t;

    function automatic vec_t v(input logic wr, input int wa, input logic [TS-1:0] wd,
                               input logic rd, input int ra, input logic vld,
                               input logic [TS-1:0] dat, input logic bsy);
        vec_t t;
        t.wr = wr; t.wa = wa; t.wd = wd; t.rd = rd; t.ra = ra;
        t.vld = vld; t.dat = dat; t.rdy = 1'b1; t.bsy = bsy; t.ovf = 1'b0;
        return t;
    endfunction

    // Transaction-level reference: accepted-address queue plus scheduled responses.
    typedef struct {
        int            due;
        logic [TS-1:0] d;
    } resp_t;

    logic [TS-1:0] mmem [256];
    int            aq [$];
    resp_t         sched [$];
    int            edge_n = 0;
    logic          m_vld, m_rdy, m_busy, m_ovf;
    logic [TS-1:0] m_dat;

    task automatic model_edge(input logic w, input int wa, input logic [TS-1:0] wd,
                              input logic r, input int ra);
        bit    acc;
        int    a;
        resp_t t;
        acc = r && (aq.size() != PD);
        if (r && !acc) m_ovf = 1'b1;
        if (w) begin
            mmem[wa] = wd;
            if (acc) aq.push_back(ra);
        end else if (aq.size() != 0) begin
            a = aq.pop_front();
            t.due = edge_n + RL - 1;
            t.d = mmem[a];
            sched.push_back(t);
            if (acc) aq.push_back(ra);
        end else if (acc) begin
            t.due = edge_n + RL - 1;
            t.d = mmem[ra];
            sched.push_back(t);
        end
        while (sched.size() != 0 && sched[0].due < edge_n) void'(sched.pop_front());
        m_vld = (sched.size() != 0) && (sched[0].due == edge_n);
        if (m_vld) m_dat = sched[0].d;
        m_busy = (aq.size() != 0) || (sched.size() != 0);
        m_rdy = (aq.size() != PD);
        edge_n++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    vec_t tbl [24];
    logic [TS-1:0] got [$];
    logic [TS-1:0] exp_ovf [4];
    int nv;

    initial begin
        wr_en = 0; wr_addr = 0; wr_data = 0; fibre_a_read_en = 0; fibre_a_addr = 0;
        rst_n = 1'b0;
        #12;
        check_outs("reset", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // load/read, back-to-back, same-edge write+read, write preemption
        tbl[0]  = v(1,   5, 4'b1010, 0, 0, 0, 4'b0000, 0);
        tbl[1]  = v(0,   0, 4'b0000, 1, 5, 0, 4'b0000, 1);
        tbl[2]  = v(0,   0, 4'b0000, 0, 0, 1, 4'b1010, 1);
        tbl[3]  = v(0,   0, 4'b0000, 0, 0, 0, 4'b1010, 0);
        tbl[4]  = v(1,   8, 4'b1111, 0, 0, 0, 4'b1010, 0);
        tbl[5]  = v(1,  12, 4'b0011, 0, 0, 0, 4'b1010, 0);
        tbl[6]  = v(1,  15, 4'b0000, 0, 0, 0, 4'b1010, 0);
        tbl[7]  = v(0,   0, 4'b0000, 1, 8, 0, 4'b1010, 1);
        tbl[8]  = v(0,   0, 4'b0000, 1, 12, 1, 4'b1111, 1);
        tbl[9]  = v(0,   0, 4'b0000, 1, 15, 1, 4'b0011, 1);
        tbl[10] = v(0,   0, 4'b0000, 0, 0, 1, 4'b0000, 1);
        tbl[11] = v(0,   0, 4'b0000, 0, 0, 0, 4'b0000, 0);
        tbl[12] = v(1,   5, 4'b0101, 1, 5, 0, 4'b0000, 1);
        tbl[13] = v(0,   0, 4'b0000, 0, 0, 0, 4'b0000, 1);
        tbl[14] = v(0,   0, 4'b0000, 0, 0, 1, 4'b0101, 1);
        tbl[15] = v(0,   0, 4'b0000, 0, 0, 0, 4'b0101, 0);
        tbl[16] = v(1,   5, 4'b1010, 0, 0, 0, 4'b0101, 0);
        tbl[17] = v(1, 200, 4'b0110, 1, 5, 0, 4'b0101, 1);
        tbl[18] = v(1, 201, 4'b1001, 1, 8, 0, 4'b0101, 1);
        tbl[19] = v(1, 202, 4'b0001, 0, 0, 0, 4'b0101, 1);
        tbl[20] = v(0,   0, 4'b0000, 0, 0, 0, 4'b0101, 1);
        tbl[21] = v(0,   0, 4'b0000, 0, 0, 1, 4'b1010, 1);
        tbl[22] = v(0,   0, 4'b0000, 0, 0, 1, 4'b1111, 1);
        tbl[23] = v(0,   0, 4'b0000, 0, 0, 0, 4'b1111, 0);

        for (int i = 0; i < 24; i++) begin
            step(tbl[i].wr, tbl[i].wa, tbl[i].wd, tbl[i].rd, tbl[i].ra);
            check_outs($sformatf("vec%0d", i), tbl[i].vld, tbl[i].dat, tbl[i].rdy,
                       tbl[i].bsy, tbl[i].ovf);
        end

        // Overflow: five reads under continuous writes, the fifth is dropped.
        exp_ovf[0] = 4'b1010; exp_ovf[1] = 4'b1111; exp_ovf[2] = 4'b0011; exp_ovf[3] = 4'b0000;
        step(1, 230, 4'b0111, 1, 5);
        check("ovf ready1", 32'(req_ready), 32'd1);
        step(1, 231, 4'b0111, 1, 8);
        step(1, 232, 4'b0111, 1, 12);
        check("ovf ready3", 32'(req_ready), 32'd1);
        step(1, 233, 4'b0111, 1, 15);
        check("ovf ready4", 32'(req_ready), 32'd0);
        check("ovf flag4", 32'(req_overflow), 32'd0);
        step(1, 234, 4'b0111, 1, 8);
        check("ovf flag5", 32'(req_overflow), 32'd1);
        check("ovf valid5", 32'(fibre_a_valid), 32'd0);
        got.delete();
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 4'b0000, 0, 0);
            if (fibre_a_valid) got.push_back(fibre_a_data);
        end
        check("ovf resp count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            check($sformatf("ovf resp%0d", i), 32'(got[i]), 32'(exp_ovf[i]));
        check("ovf sticky", 32'(req_overflow), 32'd1);
        check("ovf idle busy", 32'(busy), 32'd0);

        // Reset mid-stream with three requests queued behind writes.
        step(1, 240, 4'b1100, 1, 8);
        step(1, 241, 4'b1100, 1, 12);
        step(1, 242, 4'b1100, 1, 15);
        check("pre-rst busy", 32'(busy), 32'd1);
        wr_en = 0; fibre_a_read_en = 0;
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("midrst", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        nv = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 4'b0000, 0, 0);
            if (fibre_a_valid) nv++;
        end
        check("postrst no resp", 32'(nv), 32'd0);
        step(0, 0, 4'b0000, 1, 5);
        check_outs("postrst rd", 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        step(0, 0, 4'b0000, 0, 0);
        check_outs("postrst resp", 1'b1, 4'b1010, 1'b1, 1'b1, 1'b0);
        step(0, 0, 4'b0000, 0, 0);
        check_outs("postrst idle", 1'b0, 4'b1010, 1'b1, 1'b0, 1'b0);

        // Randomized traffic against the reference model.
        m_ovf = 1'b0;
        m_dat = 4'b1010;
        for (int a = 0; a < 16; a++) begin
            logic [TS-1:0] d;
            d = TS'($urandom);
            model_edge(1, a, d, 0, 0);
            step(1, a, d, 0, 0);
            check_outs($sformatf("fill%0d", a), m_vld, m_dat, m_rdy, m_busy, m_ovf);
        end
        for (int c = 0; c < 420; c++) begin
            logic w, r;
            int wa, ra;
            logic [TS-1:0] d;
            if (c >= 400) begin
                w = 0; r = 0;
            end else begin
                w = ($urandom_range(0, 99) < (((c / 50) % 2) ? 60 : 15));
                r = ($urandom_range(0, 99) < 65);
            end
            wa = $urandom_range(0, 15);
            ra = $urandom_range(0, 15);
            d = TS'($urandom);
            model_edge(w, wa, d, r, ra);
            step(w, wa, d, r, ra);
            check_outs($sformatf("rand%0d", c), m_vld, m_dat, m_rdy, m_busy, m_ovf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
